// File: rtl/seq_mon_pkg.sv
// rtl/seq_mon_pkg.sv - shared state encoding and default widths for the match monitor
package seq_mon_pkg;
    localparam int WIN_W_DEF = 16;
    localparam int CNT_W_DEF = 8;
    localparam int TOT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_e;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, clear wins over increment
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;
endmodule

// File: rtl/seq_match_monitor.sv
// rtl/seq_match_monitor.sv - windowed match counter with sticky threshold alarm
module seq_match_monitor
    import seq_mon_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOT_W = TOT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] threshold,
    input  logic             alarm_clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] win_cnt,
    output logic [WIN_W-1:0] last_pos,
    output logic [TOT_W-1:0] total_cnt,
    output logic             alarm
);
    state_e           state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] bit_idx_q, bit_idx_d;
    logic [WIN_W-1:0] last_pos_q, last_pos_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic             alarm_q, alarm_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             win_inc;
    logic             alarm_set;
    logic [CNT_W-1:0] final_cnt;

    sat_counter #(.W(CNT_W)) u_win_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .inc (win_inc),
        .q   (win_cnt)
    );

    sat_counter #(.W(TOT_W)) u_total_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (det),
        .q   (total_cnt)
    );

    always_comb begin
        accept     = (state_q == IDLE) && start && (win_len != '0) && !abort;
        win_inc    = (state_q == RUN) && det;
        // Count as it will stand after this edge, so the last bit can trip the alarm.
        final_cnt  = (win_inc && (win_cnt != '1)) ? win_cnt + 1'b1 : win_cnt;
        state_d    = state_q;
        len_d      = len_q;
        thr_d      = thr_q;
        bit_idx_d  = bit_idx_q;
        last_pos_d = last_pos_q;
        alarm_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d      = win_len;
                    thr_d      = threshold;
                    bit_idx_d  = '0;
                    last_pos_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                bit_idx_d = bit_idx_q + 1'b1;
                if (det) begin
                    last_pos_d = bit_idx_q;
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_idx_q == len_q - 1'b1) begin
                    state_d   = REPORT;
                    alarm_set = (thr_q != '0) && (final_cnt >= thr_q);
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        alarm_d = alarm_set || (alarm_q && !alarm_clr);
        done_d  = (state_d == REPORT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            thr_q      <= '0;
            bit_idx_q  <= '0;
            last_pos_q <= '0;
            alarm_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            thr_q      <= thr_d;
            bit_idx_q  <= bit_idx_d;
            last_pos_q <= last_pos_d;
            alarm_q    <= alarm_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign last_pos = last_pos_q;
    assign alarm    = alarm_q;
endmodule
